// File: rtl/lighting_pkg.sv
// Shared types and constants for the cabin-lighting mode controller.
// The state encoding is the same as the mode_select encoding. This lets the
// requested mode be cast straight into the next state.
package lighting_pkg;

  typedef enum logic [1:0] {
    LT_IDLE   = 2'b00,
    LT_NORMAL = 2'b01,
    LT_DIM    = 2'b10,
    LT_EMERG  = 2'b11
  } lt_state_e;

  localparam logic [7:0] LT_NAME_I = 8'h49;  // "I"
  localparam logic [7:0] LT_NAME_N = 8'h4E;  // "N"
  localparam logic [7:0] LT_NAME_D = 8'h44;  // "D"
  localparam logic [7:0] LT_NAME_E = 8'h45;  // "E"

  localparam int unsigned LT_CNT_W = 4;

  function automatic logic [7:0] lt_name(input lt_state_e st);
    logic [7:0] name;
    name = LT_NAME_I;
    case (st)
      LT_IDLE:   name = LT_NAME_I;
      LT_NORMAL: name = LT_NAME_N;
      LT_DIM:    name = LT_NAME_D;
      LT_EMERG:  name = LT_NAME_E;
      default:   name = LT_NAME_I;
    endcase
    return name;
  endfunction

endpackage

// File: rtl/lighting_led_decode.sv
// Combinational decode of the registered state and counter into the lamp
// drive and the ASCII state tag shown on the panel.
// Ports:
//   state      in  2  registered FSM state
//   counter    in  4  registered pattern counter
//   led        out 1  lamp drive, 1 = on
//   state_name out 8  ASCII tag of the state
module lighting_led_decode
  import lighting_pkg::*;
#(
  parameter int unsigned DIM_DUTY  = 4,  // on while counter < DIM_DUTY, 0..16
  parameter int unsigned EMERG_BIT = 1   // blink half-period is 2**EMERG_BIT clocks
) (
  input  lt_state_e   state,
  input  logic [3:0]  counter,
  output logic        led,
  output logic [7:0]  state_name
);

  // The duty value can reach 16, so the compare is one bit wider than the counter.
  localparam logic [4:0] DUTY_W = 5'(DIM_DUTY);

  logic w_dim_on;
  logic w_blink_on;

  assign w_dim_on   = ({1'b0, counter} < DUTY_W);
  assign w_blink_on = ~counter[EMERG_BIT];

  always_comb begin
    led = 1'b0;
    case (state)
      LT_IDLE:   led = 1'b0;
      LT_NORMAL: led = 1'b1;
      LT_DIM:    led = w_dim_on;
      LT_EMERG:  led = w_blink_on;
      default:   led = 1'b0;
    endcase
  end

  assign state_name = lt_name(state);

endmodule

// File: rtl/lighting_fsm.sv
// Cabin-lighting mode controller. The state register follows the crew mode
// request with one clock of latency. The pattern counter restarts on every
// change of mode. The LED pattern and ASCII tag are decoded from the registered
// state and counter.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   LT_IDLE   | lamp off, counter held at 0
//   LT_NORMAL | lamp steady on
//   LT_DIM    | PWM: on for counter < DIM_DUTY out of 16
//   LT_EMERG  | blink: on while counter[EMERG_BIT] is 0
//
// Ports:
//   clk           in  1  system clock, rising edge
//   reset         in  1  synchronous reset, active low
//   mode_select   in  2  requested mode (state encoding)
//   led           out 1  lamp drive
//   current_state out 2  registered state
//   counter       out 4  registered pattern counter
//   state_name    out 8  ASCII tag of current_state
module lighting_fsm
  import lighting_pkg::*;
#(
  parameter int unsigned DIM_DUTY  = 4,
  parameter int unsigned EMERG_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_select,
  output logic        led,
  output logic [1:0]  current_state,
  output logic [3:0]  counter,
  output logic [7:0]  state_name
);

  lt_state_e   r_state;
  logic [3:0]  r_counter;
  lt_state_e   w_next_state;
  logic [3:0]  w_next_counter;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= LT_IDLE;
      r_counter <= '0;
    end else begin
      r_state   <= w_next_state;
      r_counter <= w_next_counter;
    end
  end

  // Every transition is legal, so the request is the next state. A mode change
  // takes priority over counting, so each new mode starts its pattern at phase 0.
  always_comb begin
    w_next_state   = lt_state_e'(mode_select);
    w_next_counter = r_counter + 4'd1;
    if (w_next_state != r_state) begin
      w_next_counter = '0;
    end else if (r_state == LT_IDLE) begin
      w_next_counter = '0;
    end
  end

  assign current_state = r_state;
  assign counter       = r_counter;

  lighting_led_decode #(
    .DIM_DUTY  (DIM_DUTY),
    .EMERG_BIT (EMERG_BIT)
  ) u_led_decode (
    .state      (r_state),
    .counter    (r_counter),
    .led        (led),
    .state_name (state_name)
  );

endmodule

// File: tb/tb_lighting_fsm.sv
// Scoreboard bench for lighting_fsm. The driver applies inputs on the falling
// edge. It advances a reference model that works in terms of mode and time
// spent in that mode, and queues the expected outputs. The monitor compares
// those outputs against the DUT after the next rising edge.
module tb_lighting_fsm;

  typedef struct {
    int st;
    int cnt;
    int led;
    int name;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] mode_select;
  logic       led;
  logic [1:0] current_state;
  logic [3:0] counter;
  logic [7:0] state_name;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 0;

  // Reference model: the current mode, and the clocks spent in it since entry.
  int m_mode = 0;
  int m_age  = 0;

  lighting_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .mode_select   (mode_select),
    .led           (led),
    .current_state (current_state),
    .counter       (counter),
    .state_name    (state_name)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t predict();
    exp_t e;
    int ph;
    ph    = (m_mode == 0) ? 0 : (m_age % 16);
    e.st  = m_mode;
    e.cnt = ph;
    case (m_mode)
      0: e.led = 0;
      1: e.led = 1;
      2: e.led = (ph < 4) ? 1 : 0;
      default: e.led = ((ph / 2) % 2 == 0) ? 1 : 0;
    endcase
    case (m_mode)
      0: e.name = 73;   // 'I'
      1: e.name = 78;   // 'N'
      2: e.name = 68;   // 'D'
      default: e.name = 69;  // 'E'
    endcase
    return e;
  endfunction

  task automatic drive(input logic r, input int m);
    @(negedge clk);
    reset       = r;
    mode_select = m[1:0];
    if (!r) begin
      m_mode = 0;
      m_age  = 0;
    end else if (m != m_mode) begin
      m_mode = m;
      m_age  = 0;
    end else begin
      m_age = m_age + 1;
    end
    exp_q.push_back(predict());
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
  endtask

  // Monitor
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",      int'(current_state), e.st);
        check("counter",    int'(counter),       e.cnt);
        check("led",        int'(led),           e.led);
        check("state_name", int'(state_name),    e.name);
      end
    end
  end

  // Driver
  initial begin
    int m;
    reset       = 1'b0;
    mode_select = 2'b11;
    // Reset held with EMERGENCY requested, then IDLE hold.
    repeat (2) drive(1'b0, 3);
    repeat (5) drive(1'b1, 0);
    // NORMAL long enough to wrap the counter.
    repeat (21) drive(1'b1, 1);
    // DIMMING across two full periods.
    repeat (33) drive(1'b1, 2);
    // EMERGENCY up to counter 6, then reset mid-pattern.
    repeat (7) drive(1'b1, 3);
    drive(1'b0, 3);
    // Rapid NORMAL/DIMMING toggling.
    for (int i = 0; i < 8; i++) drive(1'b1, (i % 2 == 0) ? 1 : 2);
    // IDLE <-> EMERGENCY direct.
    drive(1'b1, 3);
    drive(1'b1, 0);
    drive(1'b1, 3);
    // Random section: mostly holds with occasional changes and resets.
    m = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) m = $urandom_range(0, 3);
      drive(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1, m);
    end
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t: got running, expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
